clock_time_ctrl: RTL and testbench
==================================

Name: clock_time_ctrl

Overview:
Timekeeping and set-mode controller for the digital clock. It divides the system clock to a 1 Hz tick and keeps the seconds, minutes and hours counters. A button-driven FSM handles setting hours and minutes. Its hours output and hour_format flag feed the 12/24-hour display converter directly.

Parameters:
TICK_DIV, 50000000, system clocks per 1 s tick; legal range >= 2; bench uses 4.

Ports:
clk  input  1  system clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
btn_mode  input  1  mode button level, debounced and synchronised upstream
btn_inc  input  1  increment button level, debounced and synchronised upstream
btn_fmt  input  1  12/24 format toggle button level, debounced upstream
hours  output  6  current hour, 0..23, binary
minutes  output  6  current minute, 0..59
seconds  output  6  current second, 0..59
hour_format  output  1  1 = 12-hour display, 0 = 24-hour
set_mode  output  2  00 RUN, 01 SET_HOUR, 10 SET_MIN
blink  output  1  display blink enable for the field being set
tick_1hz  output  1  one-clk pulse per tick

Behaviour:
- Reset (async, rst_n=0): hours=minutes=seconds=0, prescaler=0, state RUN, hour_format=0, blink=0, tick_1hz=0, edge registers=0.
- Edge detect: each button is registered. A press is a 0->1 transition between consecutive clks. Holding a button gives exactly one press.
- Prescaler: counts 0..TICK_DIV-1 and then wraps. tick_1hz=1 for the clk in which the prescaler equals TICK_DIV-1. The prescaler runs in all states.
- RUN:
  - On tick, seconds increments; 59->0 carries into minutes.
  - minutes 59->0 carries into hours; hours 23->0.
  - A full carry takes effect in the same clk: 23:59:59 -> 00:00:00.
- FSM, advanced by mode presses: RUN -> SET_HOUR -> SET_MIN -> RUN.
  - Entering SET_HOUR clears seconds and the prescaler.
  - Leaving SET_MIN for RUN clears the prescaler, so the first tick comes TICK_DIV clks later.
- In SET_HOUR and SET_MIN:
  - Timekeeping is frozen; ticks are ignored for counting.
  - An inc press adds 1 to the selected field, modulo 24 (hours) or 60 (minutes), with no carry into other fields.
- blink: 0 in RUN. In a set state it toggles on each tick and is forced to 1 on entry to that state.
- Simultaneous events:
  - Mode and inc pressed in the same clk: mode wins and inc is discarded.
  - Tick and inc in the same clk of a set state: only inc acts.
- btn_fmt press toggles hour_format in every state and has no effect on the counters. Outputs are registered; every change appears 1 clk after the causing edge or tick.
- Illegal set_mode encoding 11 returns to RUN on the next clk.

Optional Feature:
ALARM_EN: when defined, the block adds these ports:
- inputs alarm_hours[5:0], alarm_minutes[5:0], alarm_arm
- output alarm_ring

Alarm behaviour:
- alarm_ring (reset 0) sets on the RUN tick that produces hours==alarm_hours, minutes==alarm_minutes, seconds==0, and only while alarm_arm=1.
- It clears on an inc press (the press does nothing else in RUN), on alarm_arm=0, or on the next minutes change.
- Setting the time through the set states never triggers the alarm.

When ALARM_EN is undefined, these ports and the alarm logic are absent.

Test Plan:
- Reset release with TICK_DIV=4 -> tick_1hz on every 4th clk. After 60 ticks, 00:01:00; every output was 0 during reset.
- Load 23:59:58 via the set states, then run 2 ticks -> 23:59:59, then 00:00:00 in the same clk for all three fields.
- Mode press, 25 inc presses in SET_HOUR -> hours=1. Mode press, 61 inc presses in SET_MIN -> minutes=1, seconds=0. Mode press -> RUN; first tick after 4 clks.
- Mode and inc pressed in the same clk in RUN -> set_mode=01, hours unchanged. Holding inc for 20 clks -> only +1.
- btn_fmt press while in SET_MIN -> hour_format 0->1, counters unchanged. A second press gives 0. Async reset mid-SET_HOUR -> immediate RUN, 00:00:00.
- ALARM_EN with alarm 00:02 and arm=1 -> alarm_ring rises on the tick producing 00:02:00. An inc press clears it. With arm=0 the alarm never rings.

Source files
------------

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: 1 Hz timekeeping with a button-driven hour/minute set mode.
// Define ALARM_EN to add the alarm compare inputs and the alarm_ring output.
module clock_time_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_fmt,
  output logic [5:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       hour_format,
  output logic [1:0] set_mode,
  output logic       blink,
  output logic       tick_1hz
`ifdef ALARM_EN
  ,
  input  logic [5:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       alarm_arm,
  output logic       alarm_ring
`endif
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10} state_t;
  state_t state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [5:0] hours_n, minutes_n, seconds_n;
  logic blink_n, fmt_n, mode_q, inc_q, fmt_q, mode_p, inc_p, fmt_p, tick, s_wrap, m_wrap;
  // a mode press swallows a simultaneous inc press
  assign mode_p = btn_mode & ~mode_q;
  assign inc_p = btn_inc & ~inc_q & ~mode_p;
  assign fmt_p = btn_fmt & ~fmt_q;
  assign tick = presc == P_LAST;
  assign tick_1hz = tick;
  assign set_mode = state;
  assign s_wrap = seconds == 6'd59;
  assign m_wrap = minutes == 6'd59;
  always_comb begin
    state_n = state;
    presc_n = tick ? '0 : presc + 1'b1;
    hours_n = hours;
    minutes_n = minutes;
    seconds_n = seconds;
    blink_n = 1'b0;
    fmt_n = hour_format ^ fmt_p;
    case (state)
      RUN: begin
        if (mode_p) begin
          state_n = SET_HOUR;
          presc_n = '0;
          seconds_n = '0;
          blink_n = 1'b1;
        end else if (tick) begin
          seconds_n = s_wrap ? 6'd0 : seconds + 6'd1;
          minutes_n = s_wrap ? (m_wrap ? 6'd0 : minutes + 6'd1) : minutes;
          hours_n = (s_wrap && m_wrap) ? (hours == 6'd23 ? 6'd0 : hours + 6'd1) : hours;
        end
      end
      SET_HOUR: begin
        state_n = mode_p ? SET_MIN : SET_HOUR;
        blink_n = mode_p | (blink ^ tick);
        hours_n = inc_p ? (hours == 6'd23 ? 6'd0 : hours + 6'd1) : hours;
      end
      SET_MIN: begin
        state_n = mode_p ? RUN : SET_MIN;
        presc_n = mode_p ? '0 : presc_n;
        blink_n = ~mode_p & (blink ^ tick);
        minutes_n = inc_p ? (m_wrap ? 6'd0 : minutes + 6'd1) : minutes;
      end
      default: state_n = RUN;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      presc <= '0;
      hours <= '0;
      minutes <= '0;
      seconds <= '0;
      blink <= 1'b0;
      hour_format <= 1'b0;
      mode_q <= 1'b0;
      inc_q <= 1'b0;
      fmt_q <= 1'b0;
    end else begin
      state <= state_n;
      presc <= presc_n;
      hours <= hours_n;
      minutes <= minutes_n;
      seconds <= seconds_n;
      blink <= blink_n;
      hour_format <= fmt_n;
      mode_q <= btn_mode;
      inc_q <= btn_inc;
      fmt_q <= btn_fmt;
    end
  end
`ifdef ALARM_EN
  logic ring_n;
  // only a running tick can arm the ring; set-state edits never match here
  always_comb ring_n = alarm_arm & ((state == RUN && !mode_p && tick && s_wrap &&
                       hours_n == alarm_hours && minutes_n == alarm_minutes) ||
                       (alarm_ring && !inc_p && minutes_n == minutes));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm_ring <= 1'b0;
    else alarm_ring <= ring_n;
  end
`endif
endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: directed and randomized checks against a time-of-day reference model.
module tb_clock_time_ctrl;
  localparam int TD = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_mode = 1'b0, btn_inc = 1'b0, btn_fmt = 1'b0;
  logic [5:0] hours, minutes, seconds;
  logic hour_format, blink, tick_1hz;
  logic [1:0] set_mode;
`ifdef ALARM_EN
  logic [5:0] alarm_hours = 6'd0, alarm_minutes = 6'd0;
  logic alarm_arm = 1'b0;
  logic alarm_ring;
`endif
  clock_time_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_fmt(btn_fmt),
    .hours(hours), .minutes(minutes), .seconds(seconds), .hour_format(hour_format),
    .set_mode(set_mode), .blink(blink), .tick_1hz(tick_1hz)
`ifdef ALARM_EN
    , .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .alarm_arm(alarm_arm),
    .alarm_ring(alarm_ring)
`endif
  );
  always #5 clk = ~clk;
  int n_checks = 0, n_errors = 0;
  // model: time of day in seconds, mode 0/1/2, cycles since last prescaler clear
  int tod, mode, ph;
  bit fmt, blk, pm, pi, pf, ring;
  task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task model_reset();
    tod = 0; mode = 0; ph = 0;
    fmt = 0; blk = 0; pm = 0; pi = 0; pf = 0; ring = 0;
  endtask
  task model_edge();
    bit mp, ip, fp, tk, clr;
    int h, m, s, old_min;
    mp = btn_mode & ~pm;
    ip = btn_inc & ~pi & ~mp;
    fp = btn_fmt & ~pf;
    tk = (ph == TD - 1);
    clr = 0;
    h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
    old_min = m;
    fmt = fmt ^ fp;
    if (mode == 0) begin
      if (mp) begin mode = 1; tod = tod - s; clr = 1; blk = 1; end
      else if (tk) tod = (tod + 1) % 86400;
    end else if (mode == 1) begin
      if (mp) begin mode = 2; blk = 1; end
      else begin
        if (ip) tod = ((h + 1) % 24) * 3600 + m * 60 + s;
        if (tk) blk = !blk;
      end
    end else begin
      if (mp) begin mode = 0; blk = 0; clr = 1; end
      else begin
        if (ip) tod = h * 3600 + ((m + 1) % 60) * 60 + s;
        if (tk) blk = !blk;
      end
    end
`ifdef ALARM_EN
    if (!alarm_arm) ring = 0;
    else if (mode == 0 && !mp && tk && tod == alarm_hours * 3600 + alarm_minutes * 60) ring = 1;
    else if (ip || (tod / 60) % 60 != old_min) ring = 0;
`endif
    ph = clr ? 0 : (ph + 1) % TD;
    pm = btn_mode; pi = btn_inc; pf = btn_fmt;
  endtask
  task check_all();
    check("hours", hours, tod / 3600);
    check("minutes", minutes, (tod / 60) % 60);
    check("seconds", seconds, tod % 60);
    check("hour_format", hour_format, fmt);
    check("set_mode", set_mode, mode);
    check("blink", blink, blk);
    check("tick_1hz", tick_1hz, ph == TD - 1);
`ifdef ALARM_EN
    check("alarm_ring", alarm_ring, ring);
`endif
  endtask
  task step(input bit m, input bit i, input bit f);
    btn_mode = m; btn_inc = i; btn_fmt = f;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask
  task press(input bit m, input bit i, input bit f);
    step(m, i, f);
    step(0, 0, 0);
  endtask
  task do_reset();
    #2 rst_n = 1'b0;
    btn_mode = 0; btn_inc = 0; btn_fmt = 0;
    model_reset();
    #1 check_all();
    check("rst_set_mode", set_mode, 0);
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask
  initial begin
    do_reset();
    repeat (TD * 60) step(0, 0, 0);
    check("t1_hours", hours, 0);
    check("t1_minutes", minutes, 1);
    check("t1_seconds", seconds, 0);
    do_reset();
    press(1, 0, 0);
    repeat (23) press(0, 1, 0);
    press(1, 0, 0);
    repeat (59) press(0, 1, 0);
    step(1, 0, 0);
    repeat (58 * TD) step(0, 0, 0);
    check("t2_load_h", hours, 23);
    check("t2_load_m", minutes, 59);
    check("t2_load_s", seconds, 58);
    repeat (TD) step(0, 0, 0);
    check("t2_59s", seconds, 59);
    repeat (TD) step(0, 0, 0);
    check("t2_wrap_h", hours, 0);
    check("t2_wrap_m", minutes, 0);
    check("t2_wrap_s", seconds, 0);
    do_reset();
    press(1, 0, 0);
    repeat (25) press(0, 1, 0);
    check("t3_hours", hours, 1);
    press(1, 0, 0);
    repeat (61) press(0, 1, 0);
    check("t3_minutes", minutes, 1);
    check("t3_seconds", seconds, 0);
    step(1, 0, 0);
    check("t3_run", set_mode, 0);
    repeat (TD - 1) step(0, 0, 0);
    check("t3_first_tick", tick_1hz, 1);
    check("t3_no_count_yet", seconds, 0);
    step(0, 0, 0);
    check("t3_counted", seconds, 1);
    step(1, 1, 0);
    check("t4_mode_wins", set_mode, 1);
    check("t4_hours_kept", hours, 1);
    step(0, 0, 0);
    repeat (20) step(0, 1, 0);
    check("t4_hold_once", hours, 2);
    step(0, 0, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    check("t5_fmt_on", hour_format, 1);
    check("t5_min_kept", minutes, 1);
    check("t5_hr_kept", hours, 2);
    press(0, 0, 1);
    check("t5_fmt_off", hour_format, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    check("t5_in_set_hour", set_mode, 1);
    do_reset();
    check("t5_rst_hours", hours, 0);
`ifdef ALARM_EN
    alarm_hours = 6'd0; alarm_minutes = 6'd2; alarm_arm = 1'b1;
    repeat (TD * 120) step(0, 0, 0);
    check("al_ring", alarm_ring, 1);
    press(0, 1, 0);
    check("al_inc_clear", alarm_ring, 0);
    do_reset();
    alarm_arm = 1'b0;
    repeat (TD * 121) step(0, 0, 0);
    check("al_disarmed", alarm_ring, 0);
    alarm_arm = 1'b1;
`endif
    repeat (3000) begin
`ifdef ALARM_EN
      if ($urandom_range(0, 99) == 0) begin
        alarm_hours = 6'(tod / 3600);
        alarm_minutes = 6'(((tod / 60) + 1) % 60);
        alarm_arm = 1'($urandom_range(0, 3) != 0);
      end
`endif
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 20) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
